matmat_loader: RTL

- Upstream stage of the combinational matmatN fixed-point multiplier.
- Accepts matrix elements serially over a valid/ready stream: all of A row-major, then all of B row-major.
- Assembles them into the flat MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH buses the multiplier consumes.
- Holds a completed pair stable under a valid/ready output handshake until the downstream consumer takes it.

---
 rtl/matmat_pkg.sv | 26 ++
 rtl/matmat_loader.sv | 126 ++++++++++++
 2 files changed

// File: rtl/matmat_pkg.sv
// matmat_pkg: shared definitions for the matmatN loader.
//   state_e    - loader states (LOAD_A, LOAD_B, HOLD)
//   idx_width  - element-index width, max(1, clog2(N*N))
//   elem_k     - flat element index for (row, col) in an N x N matrix
package matmat_pkg;

   typedef enum logic [1:0] {
      LOAD_A = 2'd0,
      LOAD_B = 2'd1,
      HOLD   = 2'd2
   } state_e;

   // At least one bit, so that N = 1 still has a legal index port.
   function automatic int idx_width(input int n);
      int w;
      w = 0;
      while ((1 << w) < n * n) w++;
      return (w < 1) ? 1 : w;
   endfunction

   // Row-major slot number; element k lives at [k*DATA_WIDTH +: DATA_WIDTH].
   function automatic int elem_k(input int row, input int col, input int n);
      return row * n + col;
   endfunction

endpackage

// File: rtl/matmat_loader.sv
// matmat_loader: serial-to-parallel front end for the matmatN multiplier.
// Elements arrive one per handshake, A row-major then B row-major. They are
// written into two register banks. The completed pair is then held under a
// valid/ready handshake until the consumer takes it.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   flush      - synchronous abort of the pair being loaded or held
//   in_data    - element value (two's complement, DATA_WIDTH bits)
//   in_valid   - in_data valid
//   in_ready   - loader can accept an element (state != HOLD)
//   matrix_a   - assembled A, N*N*DATA_WIDTH bits, row-major
//   matrix_b   - assembled B, same layout
//   mats_valid - matrix_a/matrix_b form a complete pair (state == HOLD)
//   mats_ready - consumer accepts the pair
//   elem_idx   - slot the next accepted element is written to
//   loading_b  - next accepted element goes to B
module matmat_loader
   import matmat_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int BIN_POS     = 8,
   parameter int MATRIX_SIZE = 2
) (
   input  logic                                              clk,
   input  logic                                              rst,
   input  logic                                              flush,
   input  logic [DATA_WIDTH-1:0]                             in_data,
   input  logic                                              in_valid,
   output logic                                              in_ready,
   output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]     matrix_a,
   output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]     matrix_b,
   output logic                                              mats_valid,
   input  logic                                              mats_ready,
   output logic [idx_width(MATRIX_SIZE)-1:0]                 elem_idx,
   output logic                                              loading_b
);

   localparam int NE    = MATRIX_SIZE * MATRIX_SIZE;
   localparam int IDX_W = idx_width(MATRIX_SIZE);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NE - 1);

   // BIN_POS only travels alongside DATA_WIDTH to keep matmatN consistent;
   // reject nonsensical combinations at elaboration.
   if (MATRIX_SIZE < 1 || BIN_POS < 0 || BIN_POS >= DATA_WIDTH) begin : g_param_check
      $error("matmat_loader: illegal MATRIX_SIZE/BIN_POS/DATA_WIDTH combination");
   end

   state_e                 state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [DATA_WIDTH-1:0]  a_q [NE];
   logic [DATA_WIDTH-1:0]  b_q [NE];
   logic                   accept;
   logic                   wr_a, wr_b;

   assign in_ready   = (state_q != HOLD);
   assign mats_valid = (state_q == HOLD);
   assign loading_b  = (state_q == LOAD_B);
   assign elem_idx   = idx_q;

   // flush outranks the stream, so the element presented with it is dropped.
   assign accept = in_valid && in_ready && !flush;
   assign wr_a   = accept && (state_q == LOAD_A);
   assign wr_b   = accept && (state_q == LOAD_B);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      if (flush) begin
         state_d = LOAD_A;
         idx_d   = '0;
      end else begin
         case (state_q)
            LOAD_A, LOAD_B: begin
               if (accept) begin
                  if (idx_q == LAST_IDX) begin
                     idx_d   = '0;
                     state_d = (state_q == LOAD_A) ? LOAD_B : HOLD;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end
            end
            HOLD: begin
               // idx_q is already 0 here; no bypass into the next pair.
               if (mats_ready) state_d = LOAD_A;
            end
            default: begin
               state_d = LOAD_A;
               idx_d   = '0;
            end
         endcase
      end
   end

   // Buffers are never cleared except by reset: a new pair simply overwrites
   // every slot before it can be flagged valid again.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= LOAD_A;
         idx_q   <= '0;
         for (int k = 0; k < NE; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         for (int k = 0; k < NE; k++) begin
            if (wr_a && idx_q == IDX_W'(k)) a_q[k] <= in_data;
            if (wr_b && idx_q == IDX_W'(k)) b_q[k] <= in_data;
         end
      end
   end

   genvar gi, gj;
   for (gi = 0; gi < MATRIX_SIZE; gi++) begin : g_row
      for (gj = 0; gj < MATRIX_SIZE; gj++) begin : g_col
         localparam int K = elem_k(gi, gj, MATRIX_SIZE);
         assign matrix_a[K*DATA_WIDTH +: DATA_WIDTH] = a_q[K];
         assign matrix_b[K*DATA_WIDTH +: DATA_WIDTH] = b_q[K];
      end
   end

endmodule
